// File: rtl/detector_padrao_if.sv
// -----------------------------------------------------------------------------
// detector_padrao_if
//
// Bundles the stream, control and result signals of the serial pattern
// detector so that the detector and its driver share one port list.
//
// Signals
//   x        serial data sample                        (master -> slave)
//   en       sample valid, x accepted when high        (master -> slave)
//   pattern  target pattern, [LEN-1] oldest, [0] newest (master -> slave)
//   overlap  1 = overlapping, 0 = non-overlapping      (master -> slave)
//   clear    synchronous clear of history and counter  (master -> slave)
//   y        registered one-cycle match pulse          (slave -> master)
//   armed    LEN valid samples are held                (slave -> master)
//   count    saturating match counter                  (slave -> master)
// -----------------------------------------------------------------------------
interface detector_padrao_if #(
    parameter int LEN   = 4,
    parameter int CNT_W = 8
);
    logic             x;
    logic             en;
    logic [LEN-1:0]   pattern;
    logic             overlap;
    logic             clear;
    logic             y;
    logic             armed;
    logic [CNT_W-1:0] count;

    modport master (
        output x, en, pattern, overlap, clear,
        input  y, armed, count
    );

    modport slave (
        input  x, en, pattern, overlap, clear,
        output y, armed, count
    );
endinterface

// File: rtl/detector_padrao.sv
// -----------------------------------------------------------------------------
// detector_padrao
//
// Parametrised serial pattern detector. Accepted samples of x (en=1) are
// shifted into a LEN-bit history, newest in bit 0. Once LEN valid samples are
// held, every accepted sample whose resulting history equals `pattern`
// produces a one-cycle registered pulse on y and bumps a saturating counter.
// In non-overlapping mode a match flushes the history, so the next match
// needs LEN fresh samples. `pattern` is compared live and is never latched.
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    detector_padrao_if.slave (x, en, pattern, overlap, clear in;
//          y, armed, count out)
//
// Parameters
//   LEN    pattern length, 2..16
//   CNT_W  match counter width, 1..16
// -----------------------------------------------------------------------------
module detector_padrao #(
    parameter int LEN   = 4,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    detector_padrao_if.slave        bus
);

    // fill must be able to hold the value LEN itself, hence LEN+1 codes.
    localparam int                 FILL_W  = $clog2(LEN + 1);
    localparam logic [FILL_W-1:0]  FILL_MAX = FILL_W'(LEN);
    localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};

    // The FSM mirrors the fill level: FILL while history is partial, ARMED
    // once LEN valid samples are held. Keeping it as an explicit register
    // lets `armed` come straight from a flop.
    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [LEN-1:0]     hist_q,  hist_d;
    logic [FILL_W-1:0]  fill_q,  fill_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               y_q,     y_d;

    // Values the history and fill level would take if the current sample
    // is accepted and does not trigger a flush.
    logic [LEN-1:0]     next_hist;
    logic [FILL_W-1:0]  next_fill;
    logic               match;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop regardless of order.
    // The history is a plain shift register, not a memory, so it is reset
    // together with the rest of the state to discard partial sequences.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            hist_q  <= '0;
            fill_q  <= '0;
            count_q <= '0;
            y_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            count_q <= count_d;
            y_q     <= y_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-sample history and fill level
    // -------------------------------------------------------------------------
    always_comb begin
        next_hist = {hist_q[LEN-2:0], bus.x};
        // Saturating increment of fill: min(fill + 1, LEN). In ARMED the
        // history is already full and stays full.
        unique case (state_q)
            FILL:    next_fill = (fill_q == FILL_MAX) ? FILL_MAX
                                                      : fill_q + FILL_W'(1);
            ARMED:   next_fill = FILL_MAX;
            default: next_fill = FILL_MAX;
        endcase
        match = (next_fill == FILL_MAX) && (next_hist == bus.pattern);
    end

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned below gets a default first, so no path
        // through the block leaves a value unassigned and no latch is inferred.
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        count_d = count_q;
        y_d     = 1'b0;

        if (bus.clear) begin
            // clear wins over en: the concurrent sample is dropped.
            state_d = FILL;
            hist_d  = '0;
            fill_d  = '0;
            count_d = '0;
        end else if (bus.en) begin
            if (match) begin
                y_d = 1'b1;
                // y still pulses once the counter has saturated.
                if (count_q != CNT_MAX) begin
                    count_d = count_q + CNT_W'(1);
                end
                if (bus.overlap) begin
                    state_d = ARMED;
                    hist_d  = next_hist;
                    fill_d  = FILL_MAX;
                end else begin
                    // Non-overlapping: restart from an empty history.
                    state_d = FILL;
                    hist_d  = '0;
                    fill_d  = '0;
                end
            end else begin
                hist_d  = next_hist;
                fill_d  = next_fill;
                state_d = (next_fill == FILL_MAX) ? ARMED : FILL;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.y     = y_q;
    assign bus.armed = (state_q == ARMED);
    assign bus.count = count_q;

endmodule

// File: doc/detector_padrao.md
# detector_padrao

Parametrised serial pattern detector; the successor to the fixed three-ones run detector. Samples a 1-bit serial stream `x` under an enable and compares the last `LEN` accepted samples against a run-time-programmable pattern. On each match it raises a one-cycle registered hit and increments a saturating match counter. Overlapping and non-overlapping detection are both selectable. A run-of-ones detector is the special case `pattern` = all ones.

## Interface
- `LEN`, 4, pattern length in bits; legal range 2..16.
- `CNT_W`, 8, match counter width; legal range 1..16.

- `clk` in 1, the single clock; all state updates on its rising edge.
- `rst_n` in 1, asynchronous, active-low reset.
- `x` in 1, serial data sample.
- `en` in 1, sample valid; `x` is accepted only on edges where `en`=1.
- `pattern` in LEN, target pattern. `pattern[LEN-1]` is the oldest bit and `pattern[0]` is the newest bit. It is compared live, not latched.
- `overlap` in 1: 1 = overlapping detection, 0 = non-overlapping. Sampled on each matching edge.
- `clear` in 1, synchronous clear of history, fill and counter.
- `y` out 1, registered match pulse.
- `armed` out 1, high when `LEN` valid samples are held (`fill`==`LEN`).
- `count` out CNT_W, number of matches, saturating.

## Operation
- **Internal state**
  - `hist[LEN-1:0]`: shift register, newest sample in bit 0.
  - `fill`: 0..`LEN`, the count of valid history bits.
- **FSM** (encoded by `fill`)
  - FILL: `fill` < `LEN`.
  - ARMED: `fill` == `LEN`.
- **Accepted sample** (`en`=1, `clear`=0)
  - `next_hist` = {`hist[LEN-2:0]`, `x`}.
  - `next_fill` = min(`fill`+1, `LEN`).
  - `match` = (`next_fill` == `LEN`) && (`next_hist` == `pattern`).
- **On match**
  - `y` <= 1.
  - `count` <= `count`+1, unless `count` = 2^`CNT_W`−1, in which case it holds.
  - If `overlap`=1: `hist` <= `next_hist`, `fill` <= `LEN`.
  - If `overlap`=0: `hist` <= 0, `fill` <= 0, and the FSM returns to FILL. The next match therefore needs `LEN` fresh samples.
- **On no match**
  - `hist` <= `next_hist`, `fill` <= `next_fill`, `y` <= 0.
- **`en`=0**
  - `hist`, `fill` and `count` hold. `y` <= 0.
  - Gaps in `en` do not break a sequence; only accepted samples count.
- **`clear`=1**
  - `hist`, `fill` and `count` go to 0, and `y` <= 0.
  - `clear` takes priority over `en`; the concurrent sample is discarded.
- **`pattern` change mid-stream**: takes effect on the next accepted sample. History is not flushed.

## Timing
- **Reset**: `rst_n`=0 forces `y`=0, `armed`=0, `count`=0, `hist`=0 and `fill`=0 immediately, without waiting for `clk`.
  - Reset asserted mid-sequence discards partial history.
  - The first edge after deassertion may accept a sample.
- **Latency**: `y` goes high for exactly one cycle, in the cycle following the edge that accepted the completing sample.
  - `count` updates on that same edge.
  - Consecutive matches give back-to-back `y` pulses. This requires `overlap`=1 and `en`=1.
- **`armed`**: registered. It rises in the cycle after the `LEN`th accepted sample and falls after a non-overlapping match, `clear` or reset.
- **Minimum spacing between matches**
  - `overlap`=1: 1 accepted sample.
  - `overlap`=0: `LEN` accepted samples.
- **Saturation**: at 2^`CNT_W`−1 `count` holds, but `y` still pulses on every match.

## Test plan
- **Overlap on.** `LEN`=4, `pattern`=1011, `overlap`=1, `en`=1, stream 1,0,1,1,0,1,1.
  - `y` high in the cycles after samples 4 and 7.
  - `count`=2 at the end.
- **Overlap off.** Same stream with `overlap`=0.
  - `y` high only after sample 4.
  - `armed` falls after the match.
  - `count`=1 at the end.
- **Run of ones.** `pattern`=1111, `overlap`=1, seven consecutive 1s.
  - `y` high for 4 consecutive cycles, after samples 4 through 7.
  - `count`=4 at the end.
- **Enable gaps and saturation.** `pattern`=1011, stream 1,0,1,1 with `en`=0 for 3 cycles between each sample.
  - Exactly one `y` pulse, one cycle after the edge accepting the final 1.
  - Separately, with `CNT_W`=2 and 5 matches: `count` saturates at 3, and `y` pulses 5 times.
- **Clear priority.** After 3 bits of 1011, drive `clear`=1 and `en`=1 with `x`=1 on the same edge.
  - `count`=0, `armed`=0, `y`=0.
  - A fresh 1011 is required to produce the next hit.
- **Asynchronous reset.** Assert `rst_n`=0 between clock edges, mid-sequence, with `count`=2.
  - Outputs are 0 before the next edge.
  - After release, a partial pattern finished across the reset does not match.
